// File: rtl/bit_serializer_pkg.sv
// Shared constants and types for the bit serializer and the sequence-detector
// bench that consumes its bitstream.
package bit_serializer_pkg;

   localparam int DEFAULT_WIDTH = 8;

   typedef enum logic {
      ORDER_MSB_FIRST = 1'b0,
      ORDER_LSB_FIRST = 1'b1
   } bit_order_t;

   // Pattern recognised by the downstream sequence detector.
   localparam logic [4:0] PATTERN_11011 = 5'b11011;

   // The shifter state is exactly the "active" flag.
   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_SHIFT = 1'b1
   } ser_state_t;

endpackage

// File: rtl/bit_serializer_hold_slot.sv
// Single-entry valid/ready slot in front of the shifter. Ready depends only on
// registered state, so upstream sees no combinational path from word_valid.
module ser_hold_slot
   import bit_serializer_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] word_in,
   input  logic             word_valid,
   output logic             word_ready,
   input  logic             drain,
   output logic [WIDTH-1:0] hold_word,
   output logic             hold_full
);

   logic [WIDTH-1:0] hold_reg;
   logic             full_reg;

   assign word_ready = !full_reg && !reset;
   assign hold_word  = hold_reg;
   assign hold_full  = full_reg;

   // Accept needs an empty slot and drain needs a full one, so they never coincide;
   // a drained slot can only refill on the following edge.
   always_ff @(posedge clk) begin
      if (reset) begin
         full_reg <= 1'b0;
         hold_reg <= '0;
      end else if (word_valid && word_ready) begin
         full_reg <= 1'b1;
         hold_reg <= word_in;
      end else if (drain) begin
         full_reg <= 1'b0;
      end
   end

endmodule

// File: rtl/bit_serializer.sv
// Parallel-to-serial converter: words arrive over valid/ready, leave one bit
// per clock on dout; the hold slot lets consecutive words stream gap-free.
module bit_serializer
   import bit_serializer_pkg::*;
#(
   parameter int WIDTH     = DEFAULT_WIDTH,
   parameter bit LSB_FIRST = ORDER_MSB_FIRST
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] word_in,
   input  logic             word_valid,
   output logic             word_ready,
   output logic             dout,
   output logic             dout_valid,
   output logic             busy
);

   localparam int                CNT_W = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);

   ser_state_t       state_reg, state_next;
   logic [CNT_W-1:0] bit_cnt, cnt_next;
   logic [WIDTH-1:0] sh_reg, sh_next, sh_shifted;
   logic [WIDTH-1:0] hold_word;
   logic             hold_full;
   logic             drain;
   logic             out_bit;
   logic             active;

   ser_hold_slot #(.WIDTH(WIDTH)) u_slot (
      .clk        (clk),
      .reset      (reset),
      .word_in    (word_in),
      .word_valid (word_valid),
      .word_ready (word_ready),
      .drain      (drain),
      .hold_word  (hold_word),
      .hold_full  (hold_full)
   );

   // The output end of the shift register is fixed by the bit order.
   generate
      if (LSB_FIRST == ORDER_LSB_FIRST) begin : g_lsb
         assign sh_shifted = {1'b0, sh_reg[WIDTH-1:1]};
         assign out_bit    = sh_reg[0];
      end else begin : g_msb
         assign sh_shifted = {sh_reg[WIDTH-2:0], 1'b0};
         assign out_bit    = sh_reg[WIDTH-1];
      end
   endgenerate

   assign active     = (state_reg == ST_SHIFT);
   assign dout       = active ? out_bit : 1'b0;
   assign dout_valid = active;
   assign busy       = active || hold_full;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg <= ST_IDLE;
         bit_cnt   <= '0;
         sh_reg    <= '0;
      end else begin
         state_reg <= state_next;
         bit_cnt   <= cnt_next;
         sh_reg    <= sh_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      cnt_next   = bit_cnt;
      sh_next    = sh_reg;
      drain      = 1'b0;
      case (state_reg)
         ST_IDLE: begin
            if (hold_full) drain = 1'b1;
         end
         ST_SHIFT: begin
            if (bit_cnt == LAST) begin
               // Reloading on the last bit is what keeps dout_valid continuous.
               if (hold_full) drain = 1'b1;
               else           state_next = ST_IDLE;
            end else begin
               cnt_next = bit_cnt + 1'b1;
               sh_next  = sh_shifted;
            end
         end
         default: state_next = ST_IDLE;
      endcase
      if (drain) begin
         sh_next    = hold_word;
         cnt_next   = '0;
         state_next = ST_SHIFT;
      end
   end

endmodule

// File: tb/tb_bit_serializer.sv
// Directed bench for bit_serializer: reset, single word, streaming with
// backpressure, reset mid-word, and LSB-first ordering.
module tb_bit_serializer;
   import bit_serializer_pkg::*;

   logic       clk;
   logic       reset;
   logic [7:0] word_in;
   logic       word_valid;
   logic       word_ready, dout, dout_valid, busy;
   logic       lsb_word_ready, lsb_dout, lsb_dout_valid, lsb_busy;

   int n_compared;
   int n_mismatched;

   bit_serializer #(.WIDTH(8), .LSB_FIRST(1'b0)) dut (
      .clk        (clk),
      .reset      (reset),
      .word_in    (word_in),
      .word_valid (word_valid),
      .word_ready (word_ready),
      .dout       (dout),
      .dout_valid (dout_valid),
      .busy       (busy)
   );

   bit_serializer #(.WIDTH(8), .LSB_FIRST(1'b1)) dut_lsb (
      .clk        (clk),
      .reset      (reset),
      .word_in    (word_in),
      .word_valid (word_valid),
      .word_ready (lsb_word_ready),
      .dout       (lsb_dout),
      .dout_valid (lsb_dout_valid),
      .busy       (lsb_busy)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset      = 1'b1;
      word_valid = 1'b0;
      word_in    = 8'h00;
      tick();
      tick();
      reset = 1'b0;
      tick();
   endtask

   task automatic test_reset();
      reset      = 1'b1;
      word_valid = 1'b1;
      word_in    = 8'h3C;
      for (int i = 0; i < 3; i++) begin
         tick();
         n_compared++;
         if ({word_ready, dout_valid, dout, busy} !== 4'b0000) begin
            n_mismatched++;
            $display("FAIL reset_hold cyc%0d: ready/dv/dout/busy=%b required 0000", i,
                     {word_ready, dout_valid, dout, busy});
         end
      end
      reset      = 1'b0;
      word_valid = 1'b0;
      tick();
      n_compared++;
      if (word_ready !== 1'b1) begin
         n_mismatched++;
         $display("FAIL reset_release_ready: got %b required 1", word_ready);
      end
      tick();
      n_compared++;
      if ({busy, dout_valid} !== 2'b00) begin
         n_mismatched++;
         $display("FAIL reset_no_capture: busy/dv=%b required 00", {busy, dout_valid});
      end
   endtask

   task automatic test_single();
      logic [7:0] w;
      logic [4:0] win;
      int         hits;
      w    = 8'h1B;
      win  = '0;
      hits = 0;
      n_compared++;
      if (word_ready !== 1'b1) begin
         n_mismatched++;
         $display("FAIL single_ready_idle: got %b required 1", word_ready);
      end
      word_in    = w;
      word_valid = 1'b1;
      tick();
      word_valid = 1'b0;
      n_compared++;
      if ({dout_valid, busy} !== 2'b01) begin
         n_mismatched++;
         $display("FAIL single_latency: dv/busy=%b required 01", {dout_valid, busy});
      end
      for (int i = 0; i < 8; i++) begin
         tick();
         n_compared++;
         if ({dout_valid, dout} !== {1'b1, w[7-i]}) begin
            n_mismatched++;
            $display("FAIL single_bit%0d: dv/dout=%b required %b", i, {dout_valid, dout},
                     {1'b1, w[7-i]});
         end
         win = {win[3:0], dout};
         if (i >= 4 && win == PATTERN_11011) hits++;
      end
      tick();
      n_compared++;
      if ({dout_valid, busy} !== 2'b00) begin
         n_mismatched++;
         $display("FAIL single_end: dv/busy=%b required 00", {dout_valid, busy});
      end
      n_compared++;
      if (hits !== 1) begin
         n_mismatched++;
         $display("FAIL single_detect: pattern hits %0d required 1", hits);
      end
   endtask

   // 0x1B, 0xDB streamed back to back, then 0xA5 stalled by a full slot.
   task automatic test_back_to_back();
      logic [7:0]  words [3];
      logic [23:0] got;
      int          idx, nbits, runs, stalls, a5_cycle;
      logic        prev_valid, accept;
      words[0] = 8'h1B;
      words[1] = 8'hDB;
      words[2] = 8'hA5;
      got = '0;
      idx = 0; nbits = 0; runs = 0; stalls = 0; a5_cycle = -1;
      prev_valid = 1'b0;
      for (int cyc = 0; cyc < 60; cyc++) begin
         if (idx < 3) begin
            word_valid = 1'b1;
            word_in    = words[idx];
         end else begin
            word_valid = 1'b0;
         end
         accept = word_valid && word_ready;
         if (idx == 2 && !word_ready) stalls++;
         if (idx == 2 && accept) a5_cycle = cyc;
         tick();
         if (accept) idx++;
         if (dout_valid) begin
            got = {got[22:0], dout};
            nbits++;
            if (!prev_valid) runs++;
         end
         prev_valid = dout_valid;
      end
      word_valid = 1'b0;
      n_compared++;
      if (idx !== 3) begin
         n_mismatched++;
         $display("FAIL b2b_accepted: got %0d words required 3 (timeout)", idx);
      end
      n_compared++;
      if (nbits !== 24 || runs !== 1) begin
         n_mismatched++;
         $display("FAIL b2b_contiguous: bits %0d runs %0d required 24 and 1", nbits, runs);
      end
      n_compared++;
      if (got !== 24'h1BDBA5) begin
         n_mismatched++;
         $display("FAIL b2b_data: got %h required 1bdba5", got);
      end
      n_compared++;
      if (stalls !== 7 || a5_cycle !== 10) begin
         n_mismatched++;
         $display("FAIL backpressure: stalls %0d accept cyc %0d required 7 and 10",
                  stalls, a5_cycle);
      end
      n_compared++;
      if (busy !== 1'b0) begin
         n_mismatched++;
         $display("FAIL b2b_idle_after: busy %b required 0", busy);
      end
   endtask

   task automatic test_reset_mid_word();
      int dv_count;
      dv_count   = 0;
      word_in    = 8'hFF;
      word_valid = 1'b1;
      tick();
      word_valid = 1'b0;
      tick();
      word_in    = 8'h55;
      word_valid = 1'b1;
      tick();
      word_valid = 1'b0;
      tick();
      n_compared++;
      if ({dout_valid, dout, busy, word_ready} !== 4'b1110) begin
         n_mismatched++;
         $display("FAIL midword_pre: dv/dout/busy/ready=%b required 1110",
                  {dout_valid, dout, busy, word_ready});
      end
      reset = 1'b1;
      tick();
      n_compared++;
      if ({dout_valid, busy, word_ready} !== 3'b000) begin
         n_mismatched++;
         $display("FAIL midword_reset_edge: dv/busy/ready=%b required 000",
                  {dout_valid, busy, word_ready});
      end
      reset = 1'b0;
      for (int i = 0; i < 12; i++) begin
         tick();
         if (dout_valid || busy) dv_count++;
      end
      n_compared++;
      if (dv_count !== 0 || word_ready !== 1'b1) begin
         n_mismatched++;
         $display("FAIL midword_discard: active cycles %0d ready %b required 0 and 1",
                  dv_count, word_ready);
      end
   endtask

   task automatic test_lsb_first();
      logic [7:0] exp_bits;
      exp_bits   = 8'b11011000;
      word_in    = 8'h1B;
      word_valid = 1'b1;
      tick();
      word_valid = 1'b0;
      for (int i = 0; i < 8; i++) begin
         tick();
         n_compared++;
         if ({lsb_dout_valid, lsb_dout} !== {1'b1, exp_bits[7-i]}) begin
            n_mismatched++;
            $display("FAIL lsb_bit%0d: dv/dout=%b required %b", i,
                     {lsb_dout_valid, lsb_dout}, {1'b1, exp_bits[7-i]});
         end
      end
      tick();
      n_compared++;
      if ({lsb_dout_valid, lsb_busy} !== 2'b00) begin
         n_mismatched++;
         $display("FAIL lsb_end: dv/busy=%b required 00", {lsb_dout_valid, lsb_busy});
      end
   endtask

   initial begin
      n_compared   = 0;
      n_mismatched = 0;
      reset        = 1'b1;
      word_valid   = 1'b0;
      word_in      = 8'h00;
      test_reset();
      $display("test_reset done");
      do_reset();
      test_single();
      $display("test_single done");
      do_reset();
      test_back_to_back();
      $display("test_back_to_back done");
      do_reset();
      test_reset_mid_word();
      $display("test_reset_mid_word done");
      do_reset();
      test_lsb_first();
      $display("test_lsb_first done");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

endmodule

// File: doc/bit_serializer.md
Name: bit_serializer

Overview:
- Upstream feeder for the serial sequence-detector stage.
- Accepts parallel words over a valid/ready handshake and shifts them out one bit per clock on `dout`, qualified by `dout_valid`.
- A one-entry holding slot lets back-to-back words stream with no idle cycle between them, so the downstream detector sees a contiguous bitstream.

Parameters:
- WIDTH, 8, bits per parallel word; legal range WIDTH >= 2.
- LSB_FIRST, 0, 0 = MSB transmitted first; 1 = LSB transmitted first.

Ports:
- clk  input  1  rising-edge clock; the single clock domain.
- reset  input  1  synchronous, active-high reset.
- word_in  input  WIDTH  parallel word to serialize.
- word_valid  input  1  word_in is valid this cycle.
- word_ready  output  1  block can take a word this cycle; transfer occurs when word_valid & word_ready at a rising edge.
- dout  output  1  serial data bit (drives din of the detector).
- dout_valid  output  1  dout carries a real bit this cycle.
- busy  output  1  a word is shifting or held.

Behaviour:
- Registers:
  - hold_reg / hold_full: the one-entry slot.
  - sh_reg: shift register.
  - bit_cnt: $clog2(WIDTH) bits.
  - active: shifter running.
- Reset values (applied at the edge where reset = 1):
  - hold_full = 0, active = 0, bit_cnt = 0, sh_reg = 0.
  - Resulting outputs: dout = 0, dout_valid = 0, busy = 0.
- word_ready = !hold_full & !reset. It is combinational from registers only, with no combinational path from word_valid.
- Accept: at an edge with word_valid & word_ready, hold_reg <= word_in and hold_full <= 1.
- Load, at an edge where hold_full = 1 and either condition holds:
  - active = 0, or
  - active = 1 and bit_cnt == WIDTH-1 (last bit currently on dout).
- Load actions: sh_reg <= hold_reg, bit_cnt <= 0, active <= 1, hold_full <= 0.
- Shift: at an edge with active = 1 and bit_cnt < WIDTH-1:
  - bit_cnt increments.
  - sh_reg shifts toward the output end: left when LSB_FIRST = 0, right when LSB_FIRST = 1.
- End of word: at an edge with active = 1, bit_cnt == WIDTH-1 and hold_full = 0, active <= 0.
- dout:
  - = sh_reg[WIDTH-1] when LSB_FIRST = 0, else sh_reg[0], while active = 1.
  - Forced to 0 when active = 0.
- dout_valid = active; busy = active | hold_full.
- Latency and throughput:
  - Word accepted at edge n while idle: first bit is on dout in the cycle after edge n+1.
  - Its last bit is on dout in the cycle after edge n+WIDTH.
  - Steady-state throughput is one word per WIDTH cycles with dout_valid continuously high.
- State machine, with two states encoded by `active`:
  - IDLE to SHIFT on load.
  - SHIFT to SHIFT on shift, or on load at end of word.
  - SHIFT to IDLE at end of word with no word held.
- Boundary conditions:
  - Slot full: word_ready = 0. Upstream must hold word_in / word_valid stable, and no data is lost or overwritten.
  - Slot drained at edge e: word_ready returns high in the cycle after e. There is no same-edge refill, which is the deliberate registered-ready choice.
  - word_valid while reset = 1: ignored.
  - Reset mid-word: the in-flight word and any held word are discarded. dout_valid = 0 in the cycle after the reset edge, with no partial-word completion.
  - bit_cnt never exceeds WIDTH-1. Wrap occurs only through load or end of word.

Decomposition:
- Shared package holds:
  - Default WIDTH constant.
  - Bit-order enum or constants (MSB_FIRST = 0, LSB_FIRST = 1).
  - The 11011 pattern constant, shared with the detector bench.
- One natural sub-module: ser_hold_slot. It is the single-entry valid/ready slot holding hold_reg, hold_full and word_ready, with a drain strobe from the shifter.

Test Plan:
- Reset held 3 cycles with word_valid = 1 -> word_ready = 0, dout_valid = 0, dout = 0, busy = 0 throughout. After reset deasserts, word_ready = 1 and no word was captured.
- Idle, single word 0x1B (MSB first), accepted at edge n -> dout = 0,0,0,1,1,0,1,1 in the cycles after edges n+1 … n+8. dout_valid is high exactly those 8 cycles, then 0. Fed to the detector, z pulses once.
- Back-to-back 0x1B then 0xDB, second presented as soon as word_ready = 1 -> 16 contiguous dout_valid cycles: 00011011 11011011, no gap.
- Backpressure: third word 0xA5 presented while the slot is full -> word_ready = 0 until the slot drains. 0xA5 is then accepted and appears intact after 0xDB.
- Reset pulse after the 3rd bit of 0xFF, with a word held -> dout_valid = 0 in the cycle after the reset edge. Neither word resumes, and busy = 0.
- LSB_FIRST = 1, word 0x1B -> dout = 1,1,0,1,1,0,0,0.
